// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: steers each word access to the external synchronous
// RAM or to a small MMIO bank (TX FIFO, cycle counter, LED, scratch).
module dmem_mmio_responder #(
  parameter int          RAM_ADDR_BITS = 12,
  parameter logic [31:0] MMIO_BASE     = 32'd4096,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              address_dmem,
  input  logic [31:0]              data,
  input  logic                     wren,
  output logic [31:0]              q_dmem,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  output logic                     ram_wren,
  input  logic [31:0]              ram_q,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [15:0]              led,
  output logic                     bus_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] OFF_TXDATA   = 4'd0;
  localparam logic [3:0] OFF_TXSTATUS = 4'd1;
  localparam logic [3:0] OFF_CYCLE    = 4'd2;
  localparam logic [3:0] OFF_LED      = 4'd3;
  localparam logic [3:0] OFF_SCRATCH  = 4'd4;

  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(FIFO_DEPTH);

  logic             is_ram, is_mmio, mmio_we;
  logic [3:0]       offset;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, pop, push_req, push, overflow;
  logic [4:0]       status_count;
  logic [31:0]      cycle_cnt, scratch, mmio_rdata, rd_val;
  logic             rd_sel_ram;

  // Low offset bits suffice: the subtraction only matters inside the 16-word bank.
  assign is_ram  = (address_dmem[31:RAM_ADDR_BITS] == '0);
  assign is_mmio = (address_dmem >= MMIO_BASE) && (address_dmem <= MMIO_BASE + 32'd15);
  assign offset  = address_dmem[3:0] - MMIO_BASE[3:0];
  assign mmio_we = wren & is_mmio;

  assign ram_addr  = address_dmem[RAM_ADDR_BITS-1:0];
  assign ram_wdata = data;
  assign ram_wren  = wren & is_ram;

  assign full         = (count == CNT_MAX);
  assign empty        = (count == '0);
  assign tx_valid     = ~empty;
  assign tx_data      = fifo_mem[rd_ptr];
  assign pop          = tx_valid & tx_ready;
  assign push_req     = mmio_we & (offset == OFF_TXDATA);
  assign push         = push_req & (~full | pop);
  assign status_count = 5'(count);

  always_comb begin
    // NOTE: default assignment first so every path drives mmio_rdata -- no latch.
    mmio_rdata = '0;
    if (is_mmio) begin
      case (offset)
        OFF_TXSTATUS: mmio_rdata = {23'd0, status_count, 1'b0, overflow, empty, full};
        OFF_CYCLE:    mmio_rdata = cycle_cnt;
        OFF_LED:      mmio_rdata = {16'd0, led};
        OFF_SCRATCH:  mmio_rdata = scratch;
        default:      mmio_rdata = '0;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      cycle_cnt  <= '0;
      led        <= '0;
      scratch    <= '0;
      bus_err    <= 1'b0;
      rd_sel_ram <= 1'b0;
      rd_val     <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so all registers see pre-edge values.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      if (push_req && full && !pop)
        overflow <= 1'b1;
      else if (mmio_we && offset == OFF_TXSTATUS && data[2])
        overflow <= 1'b0;

      cycle_cnt <= (mmio_we && offset == OFF_CYCLE) ? '0 : cycle_cnt + 32'd1;
      if (mmio_we && offset == OFF_LED)     led     <= data[15:0];
      if (mmio_we && offset == OFF_SCRATCH) scratch <= data;
      if (!is_ram && !is_mmio)              bus_err <= 1'b1;

      rd_sel_ram <= is_ram;
      rd_val     <= mmio_rdata;
    end
  end

  assign q_dmem = rd_sel_ram ? ram_q : rd_val;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomised bench for dmem_mmio_responder: drives the data port against a queue-based
// model of the I/O bank and a shadow copy of RAM, plus directed boundary scenarios.
module tb_dmem_mmio_responder;

  localparam int          RAB   = 12;
  localparam logic [31:0] BASE  = 32'd4096;
  localparam int          DEPTH = 8;

  logic           clock, reset;
  logic [31:0]    address_dmem, data, q_dmem, ram_wdata, ram_q;
  logic           wren, ram_wren, tx_valid, tx_ready, bus_err;
  logic [RAB-1:0] ram_addr;
  logic [7:0]     tx_data;
  logic [15:0]    led;

  dmem_mmio_responder #(.RAM_ADDR_BITS(RAB), .MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
    .q_dmem(q_dmem), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_q(ram_q), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led(led), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External synchronous RAM (read-before-write).
  logic [31:0] ram [1<<RAB];
  always @(posedge clock) begin
    if (ram_wren) ram[ram_addr] <= ram_wdata;
    ram_q <= ram[ram_addr];
  end

  // Reference model state.
  logic [31:0] ram_ref [1<<RAB];
  logic [7:0]  m_fifo [$];
  logic        m_ov, m_err;
  logic [31:0] m_cnt, m_scr, m_exp_q, last_q;
  logic [15:0] m_led;
  int          n_vec, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_ov = 1'b0; m_err = 1'b0; m_cnt = '0; m_scr = '0; m_led = '0; m_exp_q = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < (32'd1 << RAB)) return ram_ref[a[RAB-1:0]];
    if (a < BASE || a > BASE + 32'd15) return 32'd0;
    case (off)
      32'd1: return 32'(m_fifo.size() << 4) | (m_ov ? 32'd4 : 32'd0) |
                    (m_fifo.size() == 0 ? 32'd2 : 32'd0) | (m_fifo.size() == DEPTH ? 32'd1 : 32'd0);
      32'd2: return m_cnt;
      32'd3: return {16'd0, m_led};
      32'd4: return m_scr;
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive after an edge, check at the falling edge, then advance the model.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit we, input bit rdy);
    bit          in_ram, in_mmio, was_full, do_pop;
    logic [31:0] off;
    address_dmem = a; data = d; wren = we; tx_ready = rdy;
    @(negedge clock);
    in_ram  = (a < (32'd1 << RAB));
    in_mmio = (a >= BASE) && (a <= BASE + 32'd15);
    off     = a - BASE;
    last_q  = q_dmem;
    check("q_dmem", q_dmem, m_exp_q);
    check("ram_wren", 32'(ram_wren), 32'(we && in_ram));
    check("tx_valid", 32'(tx_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) check("tx_data", 32'(tx_data), 32'(m_fifo[0]));
    check("led", 32'(led), 32'(m_led));
    check("bus_err", 32'(bus_err), 32'(m_err));

    m_exp_q  = model_read(a);
    was_full = (m_fifo.size() == DEPTH);
    do_pop   = (m_fifo.size() > 0) && rdy;
    if (we && in_ram) ram_ref[a[RAB-1:0]] = d;
    if (do_pop) void'(m_fifo.pop_front());
    if (we && in_mmio && off == 32'd0) begin
      if (!was_full || do_pop) m_fifo.push_back(d[7:0]);
      else m_ov = 1'b1;
    end
    if (we && in_mmio && off == 32'd1 && d[2]) m_ov = 1'b0;
    m_cnt = (we && in_mmio && off == 32'd2) ? 32'd0 : m_cnt + 32'd1;
    if (we && in_mmio && off == 32'd3) m_led = d[15:0];
    if (we && in_mmio && off == 32'd4) m_scr = d;
    if (!in_ram && !in_mmio) m_err = 1'b1;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 30) return 32'($urandom_range(0, 15));
    if (r < 33) return 32'd4095;
    if (r < 60) return BASE + 32'($urandom_range(0, 4));
    if (r < 95) return BASE + 32'($urandom_range(0, 15));
    case ($urandom_range(0, 3))
      0:       return BASE + 32'd16;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd8000;
      default: return 32'h0001_0000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    for (int i = 0; i < (1 << RAB); i++) begin ram[i] = '0; ram_ref[i] = '0; end
    ram_q = '0;
    reset = 1'b0; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_q_dmem", q_dmem, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    reset = 1'b1;

    // RAM pass-through.
    step(32'd5, 32'h1234_5678, 1'b1, 1'b0);
    step(32'd5, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("ram_readback", last_q, 32'h1234_5678);

    // FIFO fill past full with the consumer stalled, then drain.
    for (int b = 8'h41; b <= 8'h49; b++) step(BASE, 32'(b), 1'b1, 1'b0);
    check("fifo_head", 32'(tx_data), 32'h41);
    step(BASE + 32'd1, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("status_full_ovf", last_q, 32'h0000_0085);
    repeat (DEPTH + 2) step(32'd0, 32'd0, 1'b0, 1'b1);
    check("drained_valid", 32'(tx_valid), 32'd0);

    // Push while full with a simultaneous pop.
    step(BASE + 32'd1, 32'd4, 1'b1, 1'b0);
    for (int b = 8'h61; b <= 8'h68; b++) step(BASE, 32'(b), 1'b1, 1'b0);
    step(BASE, 32'h55, 1'b1, 1'b1);
    step(BASE + 32'd1, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("status_pushpop", last_q, 32'h0000_0081);
    repeat (DEPTH + 1) step(32'd0, 32'd0, 1'b0, 1'b1);

    // Cycle counter: clear, wait ten cycles, read.
    step(BASE + 32'd2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    repeat (10) step(32'd0, 32'd0, 1'b0, 1'b0);
    step(BASE + 32'd2, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("cycle_10", last_q, 32'd10);

    // Counter wrap, starting just below the top.
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cnt = 32'hFFFF_FFFE;
    repeat (3) step(BASE + 32'd2, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("cycle_wrap", last_q, 32'd0);

    // LED, scratch, reserved offsets, bank edges, unmapped.
    step(BASE + 32'd3, 32'hABCD_1234, 1'b1, 1'b0);
    check("led_value", 32'(led), 32'h1234);
    step(BASE + 32'd3, 32'd0, 1'b0, 1'b0);
    step(BASE + 32'd4, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("led_readback", last_q, 32'h0000_1234);
    step(BASE + 32'd4, 32'd0, 1'b0, 1'b0);
    step(BASE + 32'd9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("scratch_readback", last_q, 32'hCAFE_F00D);
    step(BASE + 32'd15, 32'd0, 1'b0, 1'b0);
    step(32'd4095, 32'h0BAD_F00D, 1'b1, 1'b0);
    step(32'd4095, 32'd0, 1'b0, 1'b0);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("ram_top_word", last_q, 32'h0BAD_F00D);
    check("reserved_no_err", 32'(bus_err), 32'd0);
    step(32'd8000, 32'h1111_1111, 1'b1, 1'b0);
    check("unmapped_err", 32'(bus_err), 32'd1);
    step(32'd0, 32'd0, 1'b0, 1'b0);
    check("unmapped_read", last_q, 32'd0);
    repeat (3) step(32'd1, 32'd0, 1'b0, 1'b0);
    check("err_sticky", 32'(bus_err), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      step(rand_addr(), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a drain.
    repeat (DEPTH + 1) step(32'd0, 32'd0, 1'b0, 1'b1);
    step(BASE + 32'd1, 32'd4, 1'b1, 1'b0);
    for (int b = 1; b <= 3; b++) step(BASE, 32'(b), 1'b1, 1'b0);
    address_dmem = 32'd0; wren = 1'b0; tx_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("async_tx_valid", 32'(tx_valid), 32'd0);
    check("async_q_dmem", q_dmem, 32'd0);
    check("async_led", 32'(led), 32'd0);
    check("async_bus_err", 32'(bus_err), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(BASE + 32'd2, 32'd0, 1'b0, 1'b1);
    step(BASE + 32'd3, 32'd0, 1'b0, 1'b1);
    check("post_rst_cycle", last_q, 32'd0);
    step(BASE + 32'd4, 32'd0, 1'b0, 1'b1);
    check("post_rst_led", last_q, 32'd0);
    step(BASE + 32'd1, 32'd0, 1'b0, 1'b1);
    check("post_rst_scratch", last_q, 32'd0);
    step(BASE + 32'd16, 32'd0, 1'b0, 1'b1);
    check("post_rst_status", last_q, 32'h0000_0002);
    step(32'd0, 32'd0, 1'b0, 1'b1);
    check("bank_end_err", 32'(bus_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Responder on the processor's data-memory port: decodes each word address from the pipeline's memory stage and steers it to the external data RAM or to a small bank of memory-mapped I/O registers. The I/O bank holds an 8-bit transmit FIFO with a valid/ready drain port, a free-running cycle counter, an LED register and a scratch register. It sits between the processor's `address_dmem`/`data`/`wren`/`q_dmem` port and the dmem RAM, so software can do I/O with plain `lw`/`sw`.

## Interface
- `RAM_ADDR_BITS`, 12: width of the RAM word address; RAM region is word addresses 0 .. 2^RAM_ADDR_BITS-1.
- `MMIO_BASE`, 32'd4096: first word address of the I/O bank; bank spans MMIO_BASE .. MMIO_BASE+15.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two, 2..16.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `address_dmem` in 32: word address from the memory stage.
- `data` in 32: store data.
- `wren` in 1: store enable.
- `q_dmem` out 32: load data back to the processor.
- `ram_addr` out RAM_ADDR_BITS: RAM word address, `address_dmem[RAM_ADDR_BITS-1:0]`.
- `ram_wdata` out 32: equals `data`.
- `ram_wren` out 1: `wren` AND address in RAM region.
- `ram_q` in 32: RAM read data, valid one cycle after address (synchronous RAM).
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: consumer accepts head when high with `tx_valid`.
- `led` out 16: LED register.
- `bus_err` out 1: sticky, set by any access outside both regions.

## Operation
- Region decode (combinational): RAM if `address_dmem < 2^RAM_ADDR_BITS`; MMIO if in [MMIO_BASE, MMIO_BASE+15]; otherwise unmapped. Unmapped writes are dropped, reads return 0, and `bus_err` is set until reset.
- MMIO register map, using offset = `address_dmem - MMIO_BASE`:
  - 0, TXDATA: a write pushes `data[7:0]`. Reads return 0.
  - 1, TXSTATUS: reads return bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count, all other bits 0. A write with `data[2]`=1 clears overflow; other bits are ignored.
  - 2, CYCLE: reads return the 32-bit cycle counter. It increments every clock and wraps 0xFFFFFFFF -> 0. Any write loads 0 at that edge instead of incrementing.
  - 3, LED: read/write `data[15:0]`. Reads are zero-extended.
  - 4, SCRATCH: full 32-bit read/write.
  - 5..15: reads return 0, writes are ignored. `bus_err` is not set for these offsets.
- FIFO behaviour:
  - Circular buffer with count.
  - Push when TXDATA is written and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets overflow.
  - Pop when `tx_valid & tx_ready`.
  - Push and pop together leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Read path:
  - Register the region select and the MMIO read value at each rising edge.
  - `q_dmem` = `ram_q` when the previous cycle's address was RAM, otherwise the registered MMIO/zero value.
  - A CYCLE read returns the counter value before that edge's increment.
- A write to MMIO never drives `ram_wren`.

## Timing
- Load latency is 1 cycle for every region, matching synchronous RAM: data for an address presented in cycle N appears on `q_dmem` after edge N+1.
- Stores take effect at the rising edge of the cycle they are presented.
- A TXSTATUS read in the same cycle as a push/pop returns pre-edge state.
- `tx_data`/`tx_valid` change only after a rising edge. The first pushed byte is visible the cycle after the write.
- Reset (async assert, any time, including mid-drain) sets:
  - FIFO empty, pointers 0, overflow 0.
  - counter 0, `led` 0, scratch 0, `bus_err` 0.
  - `q_dmem` 0 and the read-select register to MMIO.
  - `tx_valid` 0.
  - Queued bytes are discarded.
- Release is synchronous to `clock` in effect: the first counter increment occurs at the first edge with `reset` high.

## Test plan
- RAM pass-through: write 0x12345678 to addr 5, then read addr 5 -> `ram_wren` pulses once; `q_dmem`=0x12345678 one cycle after the read address.
- FIFO fill/overflow with `tx_ready`=0: write 0x41..0x49 (9 bytes) to TXDATA -> TXSTATUS reads full=1, count=8, overflow=1; `tx_data`=0x41. Then raise `tx_ready` -> bytes 0x41..0x48 drain in order, empty=1, `tx_valid`=0.
- Simultaneous push/pop when full, `tx_ready`=1: write 0x55 -> count stays 8 and 0x55 is the last byte out; overflow is not set.
- Counter: write CYCLE, wait 10 cycles, read -> returns 10. Force the counter near 0xFFFFFFFF and check wrap to 0.
- LED/scratch/unmapped: write LED 0xABCD_1234 -> `led`=0x1234, readback 0x00001234. Access addr 8000 -> read 0, `bus_err`=1 and sticky.
- Reset mid-operation: deassert `reset` with 3 bytes queued and `tx_ready`=1 -> `tx_valid` drops immediately (async) and all registers read 0 after release.
